br_fifo_flops_push_credit_mc: RTL and testbench
===============================================

Name: br_fifo_flops_push_credit_mc

Overview:
- Single-clock, multi-channel FIFO with a credit/valid push interface and one shared ready/valid pop interface.
- Each of NumChannels virtual channels has its own flop storage, credit counter and occupancy count.
- Pop picks among non-empty channels by round-robin.
- Sits at the receiving end of a credited link that carries several independent flows over one data bus.

Parameters:
- NumChannels, 2, number of virtual channels; >=2.
- Depth, 2, entries per channel; >=1.
- Width, 1, data width; >=1.
- MaxCredit, Depth, credit counter ceiling; >=Depth.
- RegisterPushCredit, 0, if 1, push_credit is driven from a flop (+1 cycle credit loop).
- RegisterPopOutputs, 1, if 1, pop_valid/pop_data/pop_channel come from a flop stage.
- Local: ChWidth=$clog2(NumChannels), CountWidth=$clog2(Depth+1), CreditWidth=$clog2(MaxCredit+1).

Ports:
- clk  input  1  posedge clock.
- rst  input  1  synchronous active-high reset.
- push_credit_stall  input  NumChannels  per-channel credit-return stall.
- push_credit  output  NumChannels  one credit returned for channel c per cycle asserted.
- push_valid  input  1  push data valid.
- push_channel  input  ChWidth  destination channel of the push.
- push_data  input  Width  push payload.
- pop_ready  input  1  consumer ready.
- pop_valid  output  1  pop data valid.
- pop_channel  output  ChWidth  channel of the pop data.
- pop_data  output  Width  pop payload.
- pop_empty  output  NumChannels  per-channel storage empty.
- pop_items  output  NumChannels*CountWidth  per-channel occupancy.
- credit_initial_push  input  NumChannels*CreditWidth  counter value loaded during reset.
- credit_withhold_push  input  NumChannels*CreditWidth  credits held back per channel.
- credit_count_push  output  NumChannels*CreditWidth  per-channel counter value.
- credit_available_push  output  NumChannels*CreditWidth  per-channel credits available to return.

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous, active-high.
- Reset values:
  - push_credit=0, pop_valid=0, pop_channel=0, pop_data=0.
  - pop_empty=all 1s, pop_items=0.
  - Every credit_count_push[c] is loaded from credit_initial_push[c] each cycle rst=1.
  - Storage flops are not reset.
- Reset mid-operation: all entries flushed; the round-robin pointer returns to channel 0.
- Push:
  - push_valid=1 writes push_data to the tail of channel push_channel. No ready is checked.
  - The sender owns credit correctness.
  - A push to a full channel, or with push_channel>=NumChannels, is a protocol violation. The data is dropped and no state changes.
- Dequeue:
  - An entry leaves channel storage when it is selected for pop (RegisterPopOutputs=0) or loaded into the output stage (RegisterPopOutputs=1).
  - The output stage accepts a new entry when empty, or when pop_valid & pop_ready in the same cycle.
- Credit counter, per channel c:
  - credit_available = (count > withhold) ? count - withhold : 0.
  - credit_issue[c] = !push_credit_stall[c] && credit_available[c] != 0.
  - count_next = count + deq[c] - credit_issue[c]; a simultaneous +1 and -1 leaves count unchanged.
  - count never exceeds MaxCredit; overflow is an error.
  - RegisterPushCredit=0: push_credit = credit_issue. RegisterPushCredit=1: push_credit is credit_issue delayed by one cycle.
- Arbitration:
  - Round-robin over channels with pop_empty[c]=0, starting at the pointer.
  - The pointer moves to grant+1 (mod NumChannels) on each dequeue.
  - A lone non-empty channel is granted every cycle.
- Pop stability: while pop_valid=1 and pop_ready=0, pop_valid, pop_channel and pop_data hold.
- Latency, push to pop_valid with an idle channel and no bypass:
  - 1 cycle when RegisterPopOutputs=0.
  - 2 cycles when RegisterPopOutputs=1.
- Full throughput: one push and one pop per cycle.
- pop_items[c] counts storage entries only, excluding the output stage. Push and dequeue on the same channel in the same cycle leave pop_items unchanged.
- Storage pointers wrap modulo Depth. Non-power-of-2 Depth is supported.

Optional Feature:
- Macro BR_FIFO_PUSH_CREDIT_MC_INTG_CHECKS_EN.
- When defined, assertions fire on:
  - push to a full channel;
  - push_channel>=NumChannels;
  - credit counter overflow above MaxCredit;
  - pop_valid deassert, or pop_channel/pop_data change, without pop_ready.
- When undefined, no assertions are compiled. Functional behaviour is identical: violating pushes are silently dropped.

Test Plan:
- NumChannels=2, Depth=2: reset with credit_initial_push=2 per channel, withhold=0 -> push_credit=2'b11 for 2 cycles, then 0; credit_count_push=0.
- Push ch0 data 0xA, RegisterPopOutputs=1, pop_ready=1 -> pop_valid at cycle 2 with pop_channel=0, pop_data=0xA; push_credit[0] pulses once.
- Fill ch0 and ch1 (2 each), then pop_ready=1 -> pop_channel order 0,1,0,1.
- Fill ch1 and hold pop_ready=0 for 5 cycles -> pop_data stable; pop_items[1]=1 (one entry in output stage).
- credit_withhold_push[0]=1 with count=2 -> credit_available_push[0]=1, only one credit returned; with stall[0]=1 -> no credit returned and count holds.
- Assert rst mid-traffic with 1 entry per channel -> next cycle pop_valid=0, pop_empty=2'b11, counts reload to credit_initial_push.

Source files
------------

// File: rtl/br_fifo_flops_push_credit_mc.sv
// Multi-channel flop FIFO with per-channel credit return on push and one round-robin ready/valid pop.
// Optional integrity assertions: define BR_FIFO_PUSH_CREDIT_MC_INTG_CHECKS_EN.
module br_fifo_flops_push_credit_mc #(
  parameter int unsigned NumChannels        = 2,
  parameter int unsigned Depth              = 2,
  parameter int unsigned Width              = 1,
  parameter int unsigned MaxCredit          = Depth,
  parameter int unsigned RegisterPushCredit = 0,
  parameter int unsigned RegisterPopOutputs = 1,
  localparam int unsigned ChWidth           = $clog2(NumChannels),
  localparam int unsigned CountWidth        = $clog2(Depth + 1),
  localparam int unsigned CreditWidth       = $clog2(MaxCredit + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NumChannels-1:0]              push_credit_stall,
  output logic [NumChannels-1:0]              push_credit,
  input  logic                                push_valid,
  input  logic [ChWidth-1:0]                  push_channel,
  input  logic [Width-1:0]                    push_data,
  input  logic                                pop_ready,
  output logic                                pop_valid,
  output logic [ChWidth-1:0]                  pop_channel,
  output logic [Width-1:0]                    pop_data,
  output logic [NumChannels-1:0]              pop_empty,
  output logic [NumChannels*CountWidth-1:0]   pop_items,
  input  logic [NumChannels*CreditWidth-1:0]  credit_initial_push,
  input  logic [NumChannels*CreditWidth-1:0]  credit_withhold_push,
  output logic [NumChannels*CreditWidth-1:0]  credit_count_push,
  output logic [NumChannels*CreditWidth-1:0]  credit_available_push
);

  localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

  logic [CountWidth-1:0]  items        [NumChannels];
  logic [CreditWidth-1:0] credit_count [NumChannels];
  logic [CreditWidth-1:0] credit_avail [NumChannels];
  logic [Width-1:0]       head_data_ch [NumChannels];

  logic [NumChannels-1:0] nonempty;
  logic [NumChannels-1:0] push_sel;
  logic [NumChannels-1:0] deq;
  logic [NumChannels-1:0] credit_issue;

  logic               push_ch_ok;
  logic               push_full;
  logic               push_en;
  logic               grant_valid;
  logic [ChWidth-1:0] grant_ch;
  logic [ChWidth-1:0] cand;
  logic [ChWidth-1:0] rr_ptr;
  logic [ChWidth-1:0] rr_next;
  logic               deq_en;
  logic               hold_lock;
  logic [ChWidth-1:0] hold_ch;
  logic [Width-1:0]   head_data;

  // Pushes to an out-of-range or full channel are dropped without touching state.
  always_comb begin
    push_ch_ok = 32'(push_channel) < NumChannels;
    push_full  = push_ch_ok && (items[push_channel] == CountWidth'(Depth));
    push_en    = push_valid && push_ch_ok && !push_full;
  end

  // Round-robin grant from rr_ptr; a stalled pop keeps its channel locked.
  always_comb begin
    grant_valid = 1'b0;
    grant_ch    = '0;
    cand        = '0;
    for (int unsigned i = 0; i < NumChannels; i++) begin
      cand = ChWidth'((32'(rr_ptr) + i) % NumChannels);
      if (!grant_valid && nonempty[cand]) begin
        grant_valid = 1'b1;
        grant_ch    = cand;
      end
    end
    if (hold_lock) begin
      grant_valid = 1'b1;
      grant_ch    = hold_ch;
    end
    if (rst) begin
      grant_valid = 1'b0;
      grant_ch    = '0;
    end
  end

  assign head_data = head_data_ch[grant_ch];
  assign rr_next   = (grant_ch == ChWidth'(NumChannels - 1)) ? '0 : grant_ch + ChWidth'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (deq_en) begin
      rr_ptr <= rr_next;
    end
  end

  function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
    return (p == PtrWidth'(Depth - 1)) ? '0 : p + PtrWidth'(1);
  endfunction

  for (genvar c = 0; c < NumChannels; c++) begin : g_ch
    logic [Width-1:0]       mem_q [Depth];
    logic [PtrWidth-1:0]    wr_ptr_q;
    logic [PtrWidth-1:0]    rd_ptr_q;
    logic [CountWidth-1:0]  items_q;
    logic [CreditWidth-1:0] count_q;
    logic [CreditWidth-1:0] withhold;

    assign withhold        = credit_withhold_push[c*CreditWidth +: CreditWidth];
    assign items[c]        = items_q;
    assign credit_count[c] = count_q;
    assign nonempty[c]     = (items_q != '0);
    assign head_data_ch[c] = mem_q[rd_ptr_q];
    assign push_sel[c]     = push_en && (push_channel == ChWidth'(c));
    assign deq[c]          = deq_en && (grant_ch == ChWidth'(c));
    assign credit_avail[c] = (count_q > withhold) ? count_q - withhold : '0;
    assign credit_issue[c] = !rst && !push_credit_stall[c] && (credit_avail[c] != '0);

    assign pop_empty[c]                                    = ~nonempty[c];
    assign pop_items[c*CountWidth +: CountWidth]           = items_q;
    assign credit_count_push[c*CreditWidth +: CreditWidth] = count_q;
    assign credit_available_push[c*CreditWidth +: CreditWidth] = credit_avail[c];

    // Payload storage is intentionally not reset.
    always_ff @(posedge clk) begin
      if (push_sel[c]) begin
        mem_q[wr_ptr_q] <= push_data;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        items_q  <= '0;
        count_q  <= credit_initial_push[c*CreditWidth +: CreditWidth];
      end else begin
        if (push_sel[c]) begin
          wr_ptr_q <= ptr_inc(wr_ptr_q);
        end
        if (deq[c]) begin
          rd_ptr_q <= ptr_inc(rd_ptr_q);
        end
        if (push_sel[c] && !deq[c]) begin
          items_q <= items_q + CountWidth'(1);
        end else if (!push_sel[c] && deq[c]) begin
          items_q <= items_q - CountWidth'(1);
        end
        // Dequeue returns a credit to the pool; issue takes one back out.
        if (deq[c] && !credit_issue[c]) begin
          if (count_q != CreditWidth'(MaxCredit)) begin
            count_q <= count_q + CreditWidth'(1);
          end
        end else if (!deq[c] && credit_issue[c]) begin
          count_q <= count_q - CreditWidth'(1);
        end
      end
    end
  end

  if (RegisterPushCredit != 0) begin : g_credit_reg
    logic [NumChannels-1:0] push_credit_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        push_credit_q <= '0;
      end else begin
        push_credit_q <= credit_issue;
      end
    end
    assign push_credit = push_credit_q;
  end else begin : g_credit_comb
    assign push_credit = credit_issue;
  end

  if (RegisterPopOutputs != 0) begin : g_pop_reg
    logic               out_valid_q;
    logic [ChWidth-1:0] out_ch_q;
    logic [Width-1:0]   out_data_q;

    assign hold_lock = 1'b0;
    assign hold_ch   = '0;
    assign deq_en    = grant_valid && (!out_valid_q || pop_ready);

    always_ff @(posedge clk) begin
      if (rst) begin
        out_valid_q <= 1'b0;
        out_ch_q    <= '0;
        out_data_q  <= '0;
      end else if (deq_en) begin
        out_valid_q <= 1'b1;
        out_ch_q    <= grant_ch;
        out_data_q  <= head_data;
      end else if (pop_ready) begin
        out_valid_q <= 1'b0;
      end
    end

    assign pop_valid   = out_valid_q;
    assign pop_channel = out_ch_q;
    assign pop_data    = out_data_q;
  end else begin : g_pop_comb
    logic               hold_q;
    logic [ChWidth-1:0] hold_ch_q;

    // Remember the presented channel so a late push cannot re-steer a stalled pop.
    always_ff @(posedge clk) begin
      if (rst) begin
        hold_q    <= 1'b0;
        hold_ch_q <= '0;
      end else begin
        hold_q    <= grant_valid && !pop_ready;
        hold_ch_q <= grant_ch;
      end
    end

    assign hold_lock   = hold_q;
    assign hold_ch     = hold_ch_q;
    assign deq_en      = grant_valid && pop_ready;
    assign pop_valid   = grant_valid;
    assign pop_channel = grant_ch;
    assign pop_data    = grant_valid ? head_data : '0;
  end

`ifdef BR_FIFO_PUSH_CREDIT_MC_INTG_CHECKS_EN
  logic [NumChannels-1:0] credit_ovf;
  for (genvar c = 0; c < NumChannels; c++) begin : g_ovf
    assign credit_ovf[c] = deq[c] && !credit_issue[c] &&
                           (credit_count[c] == CreditWidth'(MaxCredit));
  end

  a_push_full: assert property (@(posedge clk) disable iff (rst)
    !(push_valid && push_ch_ok && push_full));
  a_push_channel: assert property (@(posedge clk) disable iff (rst)
    !(push_valid && !push_ch_ok));
  a_credit_overflow: assert property (@(posedge clk) disable iff (rst)
    credit_ovf == '0);
  a_pop_stable: assert property (@(posedge clk) disable iff (rst)
    (pop_valid && !pop_ready) |=> (pop_valid && $stable(pop_channel) && $stable(pop_data)));
`else
  // Integrity checks compiled out; violating pushes are still dropped silently.
`endif

endmodule

// File: tb/tb_br_fifo_flops_push_credit_mc.sv
// Directed self-checking bench for br_fifo_flops_push_credit_mc (2 channels, depth 2, registered pop).
module tb_br_fifo_flops_push_credit_mc;

  localparam int unsigned NumChannels = 2;
  localparam int unsigned Depth       = 2;
  localparam int unsigned Width       = 8;
  localparam int unsigned MaxCredit   = 2;
  localparam int unsigned ChWidth     = 1;
  localparam int unsigned CountWidth  = 2;
  localparam int unsigned CreditWidth = 2;

  logic clk = 1'b0;
  logic rst;
  logic [NumChannels-1:0]             push_credit_stall;
  logic [NumChannels-1:0]             push_credit;
  logic                               push_valid;
  logic [ChWidth-1:0]                 push_channel;
  logic [Width-1:0]                   push_data;
  logic                               pop_ready;
  logic                               pop_valid;
  logic [ChWidth-1:0]                 pop_channel;
  logic [Width-1:0]                   pop_data;
  logic [NumChannels-1:0]             pop_empty;
  logic [NumChannels*CountWidth-1:0]  pop_items;
  logic [NumChannels*CreditWidth-1:0] credit_initial_push;
  logic [NumChannels*CreditWidth-1:0] credit_withhold_push;
  logic [NumChannels*CreditWidth-1:0] credit_count_push;
  logic [NumChannels*CreditWidth-1:0] credit_available_push;

  int errors = 0;
  int checks = 0;

  br_fifo_flops_push_credit_mc #(
    .NumChannels(NumChannels),
    .Depth(Depth),
    .Width(Width),
    .MaxCredit(MaxCredit),
    .RegisterPushCredit(0),
    .RegisterPopOutputs(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .push_credit_stall(push_credit_stall),
    .push_credit(push_credit),
    .push_valid(push_valid),
    .push_channel(push_channel),
    .push_data(push_data),
    .pop_ready(pop_ready),
    .pop_valid(pop_valid),
    .pop_channel(pop_channel),
    .pop_data(pop_data),
    .pop_empty(pop_empty),
    .pop_items(pop_items),
    .credit_initial_push(credit_initial_push),
    .credit_withhold_push(credit_withhold_push),
    .credit_count_push(credit_count_push),
    .credit_available_push(credit_available_push)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [ChWidth-1:0] ch, input logic [Width-1:0] data);
    push_valid   = 1'b1;
    push_channel = ch;
    push_data    = data;
    tick();
    push_valid   = 1'b0;
  endtask

  logic [ChWidth-1:0] exp_ch [4];
  logic [Width-1:0]   exp_data [4];

  initial begin
    rst                  = 1'b1;
    push_credit_stall    = '0;
    push_valid           = 1'b0;
    push_channel         = '0;
    push_data            = '0;
    pop_ready            = 1'b0;
    credit_initial_push  = {2'd2, 2'd2};
    credit_withhold_push = '0;

    // Reset state
    tick();
    tick();
    check_eq("rst_push_credit", 32'(push_credit), 32'h0);
    check_eq("rst_pop_valid", 32'(pop_valid), 32'h0);
    check_eq("rst_pop_channel", 32'(pop_channel), 32'h0);
    check_eq("rst_pop_data", 32'(pop_data), 32'h0);
    check_eq("rst_pop_empty", 32'(pop_empty), 32'h3);
    check_eq("rst_pop_items", 32'(pop_items), 32'h0);
    check_eq("rst_credit_count", 32'(credit_count_push), 32'b1010);

    // Initial credits drain two per channel
    rst = 1'b0;
    #1;
    check_eq("init_credit_c1", 32'(push_credit), 32'h3);
    tick();
    check_eq("init_credit_c2", 32'(push_credit), 32'h3);
    check_eq("init_count_c2", 32'(credit_count_push), 32'b0101);
    tick();
    check_eq("init_credit_c3", 32'(push_credit), 32'h0);
    check_eq("init_count_c3", 32'(credit_count_push), 32'h0);

    // Single push latency through the output stage
    pop_ready = 1'b1;
    push(1'b0, 8'h0A);
    check_eq("lat_c1_valid", 32'(pop_valid), 32'h0);
    check_eq("lat_c1_items", 32'(pop_items), 32'b0001);
    tick();
    check_eq("lat_c2_valid", 32'(pop_valid), 32'h1);
    check_eq("lat_c2_channel", 32'(pop_channel), 32'h0);
    check_eq("lat_c2_data", 32'(pop_data), 32'h0A);
    check_eq("lat_c2_items", 32'(pop_items), 32'h0);
    check_eq("lat_c2_credit", 32'(push_credit), 32'b01);
    tick();
    check_eq("lat_c3_valid", 32'(pop_valid), 32'h0);
    check_eq("lat_c3_credit", 32'(push_credit), 32'b00);

    // Round-robin across two filled channels
    pop_ready = 1'b0;
    push(1'b0, 8'h10);
    push(1'b0, 8'h11);
    push(1'b1, 8'h20);
    push(1'b1, 8'h21);
    check_eq("rr_fill_items", 32'(pop_items), 32'b1001);
    exp_ch[0] = 1'b0; exp_data[0] = 8'h10;
    exp_ch[1] = 1'b1; exp_data[1] = 8'h20;
    exp_ch[2] = 1'b0; exp_data[2] = 8'h11;
    exp_ch[3] = 1'b1; exp_data[3] = 8'h21;
    pop_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("rr_valid_%0d", i), 32'(pop_valid), 32'h1);
      check_eq($sformatf("rr_channel_%0d", i), 32'(pop_channel), 32'(exp_ch[i]));
      check_eq($sformatf("rr_data_%0d", i), 32'(pop_data), 32'(exp_data[i]));
      tick();
    end
    check_eq("rr_done_valid", 32'(pop_valid), 32'h0);
    check_eq("rr_done_empty", 32'(pop_empty), 32'h3);

    // Backpressure holds the output stage stable
    pop_ready = 1'b0;
    push(1'b1, 8'h30);
    push(1'b1, 8'h31);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("hold_valid_%0d", i), 32'(pop_valid), 32'h1);
      check_eq($sformatf("hold_channel_%0d", i), 32'(pop_channel), 32'h1);
      check_eq($sformatf("hold_data_%0d", i), 32'(pop_data), 32'h30);
      check_eq($sformatf("hold_items_%0d", i), 32'(pop_items), 32'b0100);
      tick();
    end
    pop_ready = 1'b1;
    tick();
    check_eq("hold_next_data", 32'(pop_data), 32'h31);
    tick();
    check_eq("hold_drained", 32'(pop_valid), 32'h0);
    tick();
    tick();
    check_eq("settle_count", 32'(credit_count_push), 32'h0);

    // Stall accumulates credits, withhold limits their return
    push_credit_stall = 2'b01;
    push(1'b0, 8'h40);
    push(1'b0, 8'h41);
    tick();
    tick();
    check_eq("stall_valid", 32'(pop_valid), 32'h0);
    check_eq("stall_count", 32'(credit_count_push), 32'b0010);
    check_eq("stall_avail", 32'(credit_available_push), 32'b0010);
    check_eq("stall_credit", 32'(push_credit), 32'b00);
    tick();
    check_eq("stall_count_hold", 32'(credit_count_push), 32'b0010);
    credit_withhold_push = {2'd0, 2'd1};
    push_credit_stall    = 2'b00;
    #1;
    check_eq("wh_avail", 32'(credit_available_push), 32'b0001);
    check_eq("wh_credit", 32'(push_credit), 32'b01);
    tick();
    check_eq("wh_count_after", 32'(credit_count_push), 32'b0001);
    check_eq("wh_credit_after", 32'(push_credit), 32'b00);
    check_eq("wh_avail_after", 32'(credit_available_push), 32'h0);
    tick();
    check_eq("wh_count_hold", 32'(credit_count_push), 32'b0001);
    credit_withhold_push = '0;
    #1;
    check_eq("wh_release_credit", 32'(push_credit), 32'b01);
    tick();
    check_eq("wh_release_count", 32'(credit_count_push), 32'h0);

    // Reset mid-traffic flushes storage and reloads counters
    pop_ready           = 1'b0;
    credit_initial_push = {2'd1, 2'd2};
    push(1'b0, 8'h50);
    push(1'b1, 8'h60);
    push(1'b0, 8'h51);
    check_eq("mid_items", 32'(pop_items), 32'b0101);
    check_eq("mid_valid", 32'(pop_valid), 32'h1);
    rst = 1'b1;
    tick();
    check_eq("mrst_valid", 32'(pop_valid), 32'h0);
    check_eq("mrst_empty", 32'(pop_empty), 32'h3);
    check_eq("mrst_items", 32'(pop_items), 32'h0);
    check_eq("mrst_count", 32'(credit_count_push), 32'b0110);
    check_eq("mrst_credit", 32'(push_credit), 32'h0);
    rst = 1'b0;
    #1;
    check_eq("mrst_credit_out", 32'(push_credit), 32'h3);
    tick();
    check_eq("mrst_count_c1", 32'(credit_count_push), 32'b0001);
    tick();
    tick();

    // Push to a full channel is dropped
    push(1'b0, 8'h80);
    push(1'b0, 8'h81);
    push(1'b0, 8'h82);
    push(1'b0, 8'h83);
    check_eq("full_items", 32'(pop_items), 32'b0010);
    check_eq("full_empty", 32'(pop_empty), 32'b10);
    pop_ready = 1'b1;
    check_eq("full_pop0", 32'(pop_data), 32'h80);
    tick();
    check_eq("full_pop1", 32'(pop_data), 32'h81);
    tick();
    check_eq("full_pop2", 32'(pop_data), 32'h82);
    tick();
    check_eq("full_dropped", 32'(pop_valid), 32'h0);
    check_eq("full_end_empty", 32'(pop_empty), 32'h3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
